fpu_floor_sched: RTL and testbench
==================================

# fpu_floor_sched

Shares one fixed-latency, non-stallable `floor` unit (single-precision, ports x1/y/clk/rstn, latency NSTAGE) between NREQ independent requesters. Round-robin arbitration with per-requester credit control; results return in order to each requester through per-requester response FIFOs. Sits between the core's issue logic (or several issuing units) and the FPU floor datapath.

## Interface
- NREQ, 2, number of requesters (2..8)
- NSTAGE, 1, pipeline latency of the instantiated `floor` unit in cycles (≥1)
- RDEPTH, 2, per-requester response FIFO depth and credit limit (≥1, power of two)

- clk  in  1  clock. One clock; all state on rising edge
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  requester i has an operand
- req_x  in  NREQ×32  operand per requester (IEEE-754 single)
- req_ready  out  NREQ  one-hot-or-zero grant; accept when valid&&ready
- resp_valid  out  NREQ  response FIFO i non-empty
- resp_y  out  NREQ×32  head of response FIFO i (floor result)
- resp_ready  in  NREQ  pop response FIFO i when valid&&ready
- busy  out  1  any request in flight or any FIFO non-empty

## Operation
- Per-requester count cnt[i] = in-flight + FIFO occupancy, range 0..RDEPTH. Requester eligible iff req_valid[i] && cnt[i] < RDEPTH.
- Round-robin: pointer rr (0..NREQ-1); grant the first eligible index searching rr, rr+1, … wrapping mod NREQ. On grant to g, rr ← (g+1) mod NREQ; no grant → rr unchanged.
- req_ready[g] = 1 only for granted g; combinational from req_valid, cnt, rr (no req_ready→req_valid dependency).
- Accept: x_q ← req_x[g]; issue-valid ← 1; tag ← g. No accept: issue-valid ← 0, x_q holds value.
- x_q drives `floor.x1`. Valid/tag shift register of length NSTAGE runs alongside; when its tail is valid, `floor.y` is pushed into FIFO[tag].
- Push can never overflow: credit guarantees space. Overflow is an assertion failure.
- cnt[i]: +1 on accept for i, −1 on pop from i; both in one cycle → unchanged.
- Results per requester leave in accept order; cross-requester order unspecified.
- Data is not inspected; denormal/NaN/Inf handling is the floor unit's.

## Timing
- Reset (async assert, sync release): req_ready=0 in the first cycle after release only if nothing valid; resp_valid=0, busy=0, rr=0, all cnt=0, issue/shift valids=0, x_q=0. In-flight ops and FIFO contents are discarded; a reset mid-operation produces no late responses.
- Latency: accept at edge E → push at edge E+NSTAGE+1 → resp_valid high in the following cycle. With resp_ready held 1: one result per requester per accept; throughput is 1 accept per cycle aggregate.
- Single requester, RDEPTH < NSTAGE+2 and consumer stalled: stream stops after RDEPTH accepts; it restarts the cycle after the first pop.
- Pop and push to the same FIFO in the same cycle, including when full or empty (push-through not allowed: resp_valid rises the cycle after push): both take effect.
- busy = |cnt.

## Structure
- Shared package `fpu_pkg`: `fpu_word_t` (32-bit), `FPU_FLOOR_NSTAGE` default constant, and tag type width $clog2(NREQ) as a parameterised localparam inside the block.
- One sub-module: `fpu_resp_fifo` (synchronous, RDEPTH entries, 32-bit, push/pop/valid, wrap-around pointers plus count). Arbiter, credit counters and tag pipe live in the top.
- Instantiates existing `floor` unchanged.

## Test plan
- Single op: req 0 sends 0x40200000 (2.5) → after NSTAGE+1 cycles resp_valid[0]=1, resp_y[0]=0x40000000; cnt returns to 0, busy=0.
- Fairness: both requesters held valid with 0xBFC00000 (−1.5) and 0x3F000000 (0.5) → grants alternate 0,1,0,1; responses 0xC0000000 and 0x00000000 respectively.
- Credit stall: RDEPTH=2, req 1 valid continuously, resp_ready[1]=0 → exactly 2 accepts, req_ready[1]=0 thereafter; one pop → exactly one more accept the next cycle.
- Ordering: req 0 issues 1.5, 2.5, 3.5 back-to-back with resp_ready varying → pops yield 1.0, 2.0, 3.0 in order.
- Reset mid-flight: assert rstn=0 one cycle after an accept → all outputs 0 immediately; after release, no resp_valid appears within 2·NSTAGE+4 cycles.
- Simultaneous push/pop on a full FIFO with accept to the other requester → no overflow assertion, cnt constant.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU word type and default floor-unit latency.
package fpu_pkg;
  typedef logic [31:0] fpu_word_t;
  localparam int FPU_FLOOR_NSTAGE = 1;
endpackage

// File: rtl/floor.sv
// floor: pipelined IEEE-754 single-precision floor.
// Ports: clk, rstn (async active-low), x1 operand in, y = floor(x1) NSTAGE cycles later.
module floor #(
  parameter int NSTAGE = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x1,
  output logic [31:0] y
);
  logic [7:0]  e;
  logic [4:0]  f;
  logic [31:0] lm, tr, rnd, r;
  logic [31:0] pipe_q [NSTAGE];
  assign e = x1[30:23];
  // f = number of fraction bits below the binary point when 127 <= e < 150
  assign f = 5'(8'd150 - e);
  assign lm = (32'd1 << f) - 32'd1;
  assign tr = x1 & ~lm;
  // negative values with a fraction round away from zero; carry may ripple into the exponent
  assign rnd = (x1[31] && |(x1 & lm)) ? tr + lm + 32'd1 : tr;
  assign r = (e >= 8'd150) ? x1 :
             (e >= 8'd127) ? rnd :
             ~|x1[30:0]    ? x1 :
             x1[31]        ? 32'hBF80_0000 : 32'h0;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NSTAGE; k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[0] <= r;
      for (int k = 1; k < NSTAGE; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end
  assign y = pipe_q[NSTAGE-1];
endmodule

// File: rtl/fpu_resp_fifo.sv
// fpu_resp_fifo: per-requester response FIFO, DEPTH entries of fpu_word_t.
// Ports: clk_i, rst_ni (async active-low), push_i/data_i write side, pop_i/valid_o/data_o read side.
module fpu_resp_fifo import fpu_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  fpu_word_t data_i,
  input  logic      pop_i,
  output logic      valid_o,
  output fpu_word_t data_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  fpu_word_t     mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign valid_o = cnt_q != '0;
  // stale entries are hidden so an empty FIFO always presents zero
  assign data_o = valid_o ? mem_q[rp_q] : '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wp_q <= nxt(wp_q);
      if (pop_i) rp_q <= nxt(rp_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wp_q] <= data_i;
  end
  no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !pop_i && cnt_q == CW'(DEPTH)));
endmodule

// File: rtl/fpu_floor_sched.sv
// fpu_floor_sched: round-robin, credit-controlled sharing of one floor unit among NREQ requesters.
// Ports: clk_i, rst_ni (async active-low); req_valid_i/req_x_i/req_ready_o issue side;
// resp_valid_o/resp_y_o/resp_ready_i per-requester response side; busy_o = any credit in use.
module fpu_floor_sched import fpu_pkg::*; #(
  parameter int NREQ   = 2,
  parameter int NSTAGE = FPU_FLOOR_NSTAGE,
  parameter int RDEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic      [NREQ-1:0] req_valid_i,
  input  fpu_word_t [NREQ-1:0] req_x_i,
  output logic      [NREQ-1:0] req_ready_o,
  output logic      [NREQ-1:0] resp_valid_o,
  output fpu_word_t [NREQ-1:0] resp_y_o,
  input  logic      [NREQ-1:0] resp_ready_i,
  output logic                 busy_o
);
  localparam int TW = $clog2(NREQ);
  localparam int CW = $clog2(RDEPTH + 1);
  logic [TW-1:0]   rr_q, rr_d, gnt, itag_q;
  logic            gnt_vld, iv_q;
  fpu_word_t       x_q, y_w;
  logic [NSTAGE-1:0] pv_q;
  logic [TW-1:0]   pt_q [NSTAGE];
  logic [CW-1:0]   cnt_q [NREQ];
  logic [CW-1:0]   cnt_d [NREQ];
  logic [NREQ-1:0] elig, push, pop;
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) elig[i] = req_valid_i[i] && cnt_q[i] < CW'(RDEPTH);
  end
  always_comb begin
    gnt_vld = 1'b0;
    gnt = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_vld && elig[TW'((int'(rr_q) + k) % NREQ)]) begin
        gnt_vld = 1'b1;
        gnt = TW'((int'(rr_q) + k) % NREQ);
      end
    end
    rr_d = !gnt_vld ? rr_q : (gnt == TW'(NREQ - 1)) ? '0 : gnt + 1'b1;
    // gated by reset so every output reads zero while reset is held
    req_ready_o = (gnt_vld && rst_ni) ? NREQ'(1) << gnt : '0;
  end
  always_comb begin
    push = '0;
    pop = '0;
    busy_o = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      push[i] = pv_q[NSTAGE-1] && pt_q[NSTAGE-1] == TW'(i);
      pop[i] = resp_valid_o[i] && resp_ready_i[i];
      cnt_d[i] = cnt_q[i] + CW'(req_ready_o[i]) - CW'(pop[i]);
      busy_o = busy_o || cnt_q[i] != '0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q   <= '0;
      iv_q   <= 1'b0;
      itag_q <= '0;
      x_q    <= '0;
      pv_q   <= '0;
      for (int k = 0; k < NSTAGE; k++) pt_q[k] <= '0;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      rr_q <= rr_d;
      iv_q <= gnt_vld;
      if (gnt_vld) begin
        x_q    <= req_x_i[gnt];
        itag_q <= gnt;
      end
      pv_q[0] <= iv_q;
      pt_q[0] <= itag_q;
      for (int k = 1; k < NSTAGE; k++) begin
        pv_q[k] <= pv_q[k-1];
        pt_q[k] <= pt_q[k-1];
      end
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end
  floor #(.NSTAGE(NSTAGE)) u_floor (
    .clk (clk_i),
    .rstn(rst_ni),
    .x1  (x_q),
    .y   (y_w)
  );
  for (genvar g = 0; g < NREQ; g++) begin : g_fifo
    fpu_resp_fifo #(.DEPTH(RDEPTH)) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push_i (push[g]),
      .data_i (y_w),
      .pop_i  (pop[g]),
      .valid_o(resp_valid_o[g]),
      .data_o (resp_y_o[g])
    );
  end
endmodule

// File: tb/tb_fpu_floor_sched.sv
// tb_fpu_floor_sched: directed table-driven bench for fpu_floor_sched (NREQ=2, NSTAGE=1, RDEPTH=2).
module tb_fpu_floor_sched;
  localparam int NSTAGE = 1;
  localparam int NV = 16;
  typedef struct {
    int          r;
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;
  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid, req_ready, resp_valid, resp_ready;
  logic [1:0][31:0] req_x, resp_y;
  logic             busy;
  int               nvec, nerr;
  int               acc0, acc1, pop0, pop1;
  logic [31:0]      ey0, ey1;
  vec_t             tv [NV];
  logic [1:0]       fexp [4];
  logic [31:0]      oxs [3];
  logic [31:0]      oys [3];
  fpu_floor_sched #(.NREQ(2), .NSTAGE(NSTAGE), .RDEPTH(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_x_i     (req_x),
    .req_ready_o (req_ready),
    .resp_valid_o(resp_valid),
    .resp_y_o    (resp_y),
    .resp_ready_i(resp_ready),
    .busy_o      (busy)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    resp_ready = '0;
    req_x = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask
  task automatic samp();
    chk("onehot", 32'($onehot0(req_ready)), 32'd1);
    if (req_valid[0] && req_ready[0]) acc0++;
    if (req_valid[1] && req_ready[1]) acc1++;
    if (resp_valid[0] && resp_ready[0]) begin
      pop0++;
      chk("pop_y0", resp_y[0], ey0);
    end
    if (resp_valid[1] && resp_ready[1]) begin
      pop1++;
      chk("pop_y1", resp_y[1], ey1);
    end
  endtask
  task automatic drain();
    req_valid = '0;
    resp_ready = 2'b11;
    for (int k = 0; k < 30; k++) begin
      #1 samp();
      if (!busy) break;
      cyc();
    end
    chk("drain_idle", busy, 0);
  endtask
  task automatic clr();
    acc0 = 0; acc1 = 0; pop0 = 0; pop1 = 0;
  endtask
  initial begin
    logic [1:0] m;
    int oi, op;
    logic seen;
    nvec = 0; nerr = 0;
    tv[0]  = '{0, 32'h4020_0000, 32'h4000_0000};
    tv[1]  = '{1, 32'hBFC0_0000, 32'hC000_0000};
    tv[2]  = '{0, 32'h3F00_0000, 32'h0000_0000};
    tv[3]  = '{1, 32'hBF00_0000, 32'hBF80_0000};
    tv[4]  = '{0, 32'h8000_0000, 32'h8000_0000};
    tv[5]  = '{1, 32'h3F80_0000, 32'h3F80_0000};
    tv[6]  = '{0, 32'hBF80_0000, 32'hBF80_0000};
    tv[7]  = '{1, 32'hC020_0000, 32'hC040_0000};
    tv[8]  = '{0, 32'h4CBE_BC20, 32'h4CBE_BC20};
    tv[9]  = '{1, 32'h7F80_0000, 32'h7F80_0000};
    tv[10] = '{0, 32'hBFE0_0000, 32'hC000_0000};
    tv[11] = '{1, 32'h4070_0000, 32'h4040_0000};
    tv[12] = '{0, 32'h0000_0001, 32'h0000_0000};
    tv[13] = '{1, 32'h8000_0001, 32'hBF80_0000};
    tv[14] = '{0, 32'h4AFF_FFFF, 32'h4AFF_FFFE};
    tv[15] = '{1, 32'hCAFF_FFFF, 32'hCB00_0000};
    fexp = '{2'b01, 2'b10, 2'b01, 2'b10};
    oxs = '{32'h3FC0_0000, 32'h4020_0000, 32'h4060_0000};
    oys = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    rst_n = 1'b0; req_valid = '0; resp_ready = '0; req_x = '0;
    #3;
    chk("rst_rv", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", req_ready, 0);
    chk("rst_y0", resp_y[0], 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("rel_rv", resp_valid, 0);
    chk("rel_busy", busy, 0);
    chk("rel_rdy", req_ready, 0);
    for (int i = 0; i < NV; i++) begin
      m = 2'b01 << tv[i].r;
      cyc();
      req_valid = m;
      req_x[tv[i].r] = tv[i].x;
      #1 chk("t_rdy", req_ready, m);
      cyc();
      req_valid = '0;
      #1 chk("t_busy", busy, 1);
      repeat (NSTAGE) begin
        cyc();
        #1 chk("t_early", resp_valid, 0);
      end
      cyc();
      #1 chk("t_rv", resp_valid, m);
      chk("t_y", resp_y[tv[i].r], tv[i].y);
      resp_ready = m;
      cyc();
      resp_ready = '0;
      #1 chk("t_idle", {resp_valid, busy}, 0);
    end
    do_reset();
    clr();
    req_valid = 2'b11;
    req_x[0] = 32'hBFC0_0000;
    req_x[1] = 32'h3F00_0000;
    resp_ready = 2'b11;
    ey0 = 32'hC000_0000;
    ey1 = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      #1 chk("fair_gnt", req_ready, fexp[k]);
      samp();
      cyc();
    end
    drain();
    chk("fair_pop0", pop0, 2);
    chk("fair_pop1", pop1, 2);
    cyc();
    clr();
    ey1 = 32'h4040_0000;
    req_x[1] = 32'h4070_0000;
    req_valid = 2'b10;
    resp_ready = '0;
    for (int k = 0; k < 8; k++) begin
      #1 chk("cr_rdy", req_ready, k < 2 ? 2'b10 : 2'b00);
      cyc();
    end
    #1 chk("cr_rv", resp_valid[1], 1);
    chk("cr_y", resp_y[1], 32'h4040_0000);
    resp_ready = 2'b10;
    #1 chk("cr_hold", req_ready, 0);
    cyc();
    resp_ready = '0;
    #1 chk("cr_restart", req_ready, 2'b10);
    cyc();
    #1 chk("cr_stop", req_ready, 0);
    drain();
    chk("cr_pops", pop1, 2);
    cyc();
    oi = 0; op = 0;
    for (int k = 0; k < 40 && op < 3; k++) begin
      req_valid = oi < 3 ? 2'b01 : 2'b00;
      req_x[0] = oxs[oi < 3 ? oi : 2];
      resp_ready = (k % 3 != 1) ? 2'b01 : 2'b00;
      #1;
      if (resp_valid[0] && resp_ready[0]) begin
        chk("ord_y", resp_y[0], oys[op]);
        op++;
      end
      if (req_valid[0] && req_ready[0]) oi++;
      cyc();
    end
    chk("ord_n", op, 3);
    drain();
    cyc();
    clr();
    ey0 = 32'hC040_0000;
    ey1 = 32'h0000_0000;
    req_x[0] = 32'hC020_0000;
    req_x[1] = 32'h3F00_0000;
    resp_ready = '0;
    req_valid = 2'b01;
    for (int k = 0; k < 10 && acc0 < 2; k++) begin
      #1 samp();
      cyc();
    end
    req_valid = '0;
    repeat (4) cyc();
    #1 chk("ff_full", resp_valid, 2'b01);
    req_valid = 2'b11;
    #1 chk("ff_nocredit", req_ready, 2'b10);
    resp_ready = 2'b11;
    for (int k = 0; k < 12; k++) begin
      #1 samp();
      cyc();
    end
    drain();
    chk("ff_bal0", pop0, acc0);
    chk("ff_bal1", pop1, acc1);
    chk("ff_acc1", 32'(acc1 > 2), 1);
    cyc();
    req_valid = 2'b01;
    req_x[0] = 32'h4020_0000;
    resp_ready = '0;
    cyc();
    req_valid = '0;
    cyc();
    req_valid = 2'b01;
    rst_n = 1'b0;
    #1;
    chk("rm_rdy", req_ready, 0);
    chk("rm_rv", resp_valid, 0);
    chk("rm_y0", resp_y[0], 0);
    chk("rm_y1", resp_y[1], 0);
    chk("rm_busy", busy, 0);
    req_valid = '0;
    repeat (2) cyc();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 2 * NSTAGE + 4; k++) begin
      #1 seen = seen | (|resp_valid);
      cyc();
    end
    chk("rm_late", seen, 0);
    chk("rm_idle", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
